// File: rtl/batch_rev_buffer.sv
// Double-banked batch buffer: fills DEPTH-sample batches and replays each one newest-first.
// Optional forward-order companion output fwd_out is enabled with `define BATCH_FWD_OUT_EN.
module batch_rev_buffer #(
  parameter int unsigned N     = 3,
  parameter int unsigned DEPTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic [N-1:0] out,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
`ifdef BATCH_FWD_OUT_EN
  output logic [N-1:0] fwd_out,
`endif
  output logic         overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned MW = AW + 1;
  localparam logic [AW-1:0] PTR_MAX  = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ZERO = '0;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_READ = 1'b1;

  // Bank b occupies addresses {b, index}
  logic [N-1:0]  mem [2*DEPTH];

  logic [0:0]    state, state_nx;
  logic [1:0]    full, full_nx, full_set, full_clr;
  logic          wb, wb_nx, rb, rb_nx;
  logic [AW-1:0] wp, wp_nx, rp, rp_nx, rp_dec;
  logic [N-1:0]  out_nx;
  logic          out_valid_nx, out_last_nx, overflow_nx;
  logic          wr_en;
  logic [MW-1:0] wr_addr;
  logic          sel, nb;
`ifdef BATCH_FWD_OUT_EN
  logic [N-1:0]  fwd_nx;
`endif

  // Oldest full bank: the write bank is the older one whenever it is still full
  assign sel    = full[wb] ? wb : ~wb;
  assign nb     = ~rb;
  assign rp_dec = rp - PTR_ONE;

  // Write side: full flags are the pre-edge values, so a bank freed this edge still drops
  always_comb begin
    wr_en       = 1'b0;
    wr_addr     = {wb, wp};
    wp_nx       = wp;
    wb_nx       = wb;
    full_set    = 2'b00;
    overflow_nx = overflow;
    if (in_valid) begin
      if (full[wb]) begin
        overflow_nx = 1'b1;
      end else begin
        wr_en = 1'b1;
        if (wp == PTR_MAX) begin
          full_set[wb] = 1'b1;
          wb_nx        = ~wb;
          wp_nx        = PTR_ZERO;
        end else begin
          wp_nx = wp + PTR_ONE;
        end
      end
    end
  end

  // Read FSM next-state and output logic
  always_comb begin
    state_nx     = state;
    rb_nx        = rb;
    rp_nx        = rp;
    out_nx       = out;
    out_valid_nx = out_valid;
    out_last_nx  = out_last;
    full_clr     = 2'b00;
`ifdef BATCH_FWD_OUT_EN
    fwd_nx       = fwd_out;
`endif
    case (state)
      S_IDLE: begin
        if (|full) begin
          state_nx     = S_READ;
          rb_nx        = sel;
          rp_nx        = PTR_MAX;
          out_nx       = mem[{sel, PTR_MAX}];
          out_valid_nx = 1'b1;
          out_last_nx  = 1'b0;
`ifdef BATCH_FWD_OUT_EN
          fwd_nx       = mem[{sel, PTR_ZERO}];
`endif
        end
      end
      S_READ: begin
        if (out_ready) begin
          if (rp != PTR_ZERO) begin
            rp_nx       = rp_dec;
            out_nx      = mem[{rb, rp_dec}];
            out_last_nx = (rp == PTR_ONE);
`ifdef BATCH_FWD_OUT_EN
            fwd_nx      = mem[{rb, PTR_MAX - rp_dec}];
`endif
          end else begin
            full_clr[rb] = 1'b1;
            if (full[nb]) begin
              rb_nx       = nb;
              rp_nx       = PTR_MAX;
              out_nx      = mem[{nb, PTR_MAX}];
              out_last_nx = 1'b0;
`ifdef BATCH_FWD_OUT_EN
              fwd_nx      = mem[{nb, PTR_ZERO}];
`endif
            end else begin
              state_nx     = S_IDLE;
              out_valid_nx = 1'b0;
              out_last_nx  = 1'b0;
            end
          end
        end
      end
      default: begin
        state_nx     = S_IDLE;
        out_valid_nx = 1'b0;
        out_last_nx  = 1'b0;
      end
    endcase
  end

  assign full_nx = (full & ~full_clr) | full_set;

  // Sample storage; contents survive reset and are simply ignored
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= in;
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      full      <= 2'b00;
      wb        <= 1'b0;
      wp        <= PTR_ZERO;
      rb        <= 1'b0;
      rp        <= PTR_ZERO;
      out       <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      overflow  <= 1'b0;
`ifdef BATCH_FWD_OUT_EN
      fwd_out   <= '0;
`endif
    end else begin
      state     <= state_nx;
      full      <= full_nx;
      wb        <= wb_nx;
      wp        <= wp_nx;
      rb        <= rb_nx;
      rp        <= rp_nx;
      out       <= out_nx;
      out_valid <= out_valid_nx;
      out_last  <= out_last_nx;
      overflow  <= overflow_nx;
`ifdef BATCH_FWD_OUT_EN
      fwd_out   <= fwd_nx;
`endif
    end
  end

endmodule

// File: tb/tb_batch_rev_buffer.sv
// Directed self-checking bench for batch_rev_buffer at N=3, DEPTH=4.
module tb_batch_rev_buffer;

  localparam int unsigned N     = 3;
  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] in;
  logic         in_valid;
  logic [N-1:0] out;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic         overflow;
`ifdef BATCH_FWD_OUT_EN
  logic [N-1:0] fwd_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  batch_rev_buffer #(.N(N), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .in       (in),
    .in_valid (in_valid),
    .out      (out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_last (out_last),
`ifdef BATCH_FWD_OUT_EN
    .fwd_out  (fwd_out),
`endif
    .overflow (overflow)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_batch(input int first);
    for (int i = 0; i < 4; i++) begin
      in       = N'(first + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in = '0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    n_cmp++;
    if ({out_valid, out_last, overflow, out} !== 6'b0) begin
      n_err++; $display("FAIL reset_async: got %b want %b", {out_valid, out_last, overflow, out}, 6'b0);
    end
    step(); step();
    rst = 1'b0;
    step();
    n_cmp++;
    if ({out_valid, out_last, overflow, out} !== 6'b0) begin
      n_err++; $display("FAIL reset_idle: got %b want %b", {out_valid, out_last, overflow, out}, 6'b0);
    end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    write_batch(1);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_latency: out_valid got %b want 0", out_valid);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if ({out_valid, out_last, out} !== {1'b1, 1'(k == 3), N'(4 - k)}) begin
        n_err++; $display("FAIL basic_seq[%0d]: got %b want %b", k, {out_valid, out_last, out}, {1'b1, 1'(k == 3), N'(4 - k)});
      end
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_idle: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_continuous();
    logic [N-1:0] seq [8];
    seq = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4};
    out_ready = 1'b1;
    for (int c = 0; c <= 12; c++) begin
      in       = N'(c);
      in_valid = (c < 8);
      step();
      if (c >= 4 && c < 12) begin
        n_cmp++;
        if ({out_valid, out_last, out} !== {1'b1, 1'(c == 7 || c == 11), seq[c-4]}) begin
          n_err++; $display("FAIL cont_seq[%0d]: got %b want %b", c - 4, {out_valid, out_last, out}, {1'b1, 1'(c == 7 || c == 11), seq[c-4]});
        end
      end else if (c == 12) begin
        n_cmp++;
        if (out_valid !== 1'b0) begin
          n_err++; $display("FAIL cont_idle: out_valid got %b want 0", out_valid);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (overflow !== 1'b0) begin
      n_err++; $display("FAIL cont_overflow: got %b want 0", overflow);
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] seq [8];
    seq = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6, 3'd5, 3'd4};
    out_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      in = N'(c); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if (overflow !== 1'b1) begin
      n_err++; $display("FAIL bp_overflow: got %b want 1", overflow);
    end
    for (int h = 0; h < 2; h++) begin
      n_cmp++;
      if ({out_valid, out_last, out} !== {1'b1, 1'b0, seq[0]}) begin
        n_err++; $display("FAIL bp_hold[%0d]: got %b want %b", h, {out_valid, out_last, out}, {1'b1, 1'b0, seq[0]});
      end
      step();
    end
    out_ready = 1'b1;
    for (int k = 1; k < 8; k++) begin
      step();
      n_cmp++;
      if ({out_valid, out_last, out} !== {1'b1, 1'(k == 3 || k == 7), seq[k]}) begin
        n_err++; $display("FAIL bp_seq[%0d]: got %b want %b", k, {out_valid, out_last, out}, {1'b1, 1'(k == 3 || k == 7), seq[k]});
      end
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL bp_idle: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_same_edge_free();
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      in = N'(c); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    n_cmp++;
    if ({overflow, out_valid, out_last, out} !== {1'b0, 1'b1, 1'b0, 3'd3}) begin
      n_err++; $display("FAIL free_pre: got %b want %b", {overflow, out_valid, out_last, out}, {1'b0, 1'b1, 1'b0, 3'd3});
    end
    out_ready = 1'b1;
    step(); step(); step();
    n_cmp++;
    if ({out_valid, out_last, out} !== {1'b1, 1'b1, 3'd0}) begin
      n_err++; $display("FAIL free_last: got %b want %b", {out_valid, out_last, out}, {1'b1, 1'b1, 3'd0});
    end
    in = 3'd5; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    n_cmp++;
    if ({overflow, out_valid, out_last, out} !== {1'b1, 1'b1, 1'b0, 3'd7}) begin
      n_err++; $display("FAIL free_drop_switch: got %b want %b", {overflow, out_valid, out_last, out}, {1'b1, 1'b1, 1'b0, 3'd7});
    end
    step(); step(); step();
    n_cmp++;
    if ({out_valid, out_last, out} !== {1'b1, 1'b1, 3'd4}) begin
      n_err++; $display("FAIL free_tail: got %b want %b", {out_valid, out_last, out}, {1'b1, 1'b1, 3'd4});
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL free_idle: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    rst = 1'b1; step(); rst = 1'b0;
    out_ready = 1'b1;
    write_batch(1);
    step();
    rst = 1'b1;
    #2;
    n_cmp++;
    if ({out_valid, out_last, overflow, out} !== 6'b0) begin
      n_err++; $display("FAIL reset_mid_read: got %b want %b", {out_valid, out_last, overflow, out}, 6'b0);
    end
    step();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in = N'(i + 1); in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++;
    if ({out_valid, out_last, overflow, out} !== 6'b0) begin
      n_err++; $display("FAIL reset_mid_batch: got %b want %b", {out_valid, out_last, overflow, out}, 6'b0);
    end
    write_batch(5);
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if ({out_valid, out_last, out} !== {1'b1, 1'(k == 3), N'(8 - k)}) begin
        n_err++; $display("FAIL post_reset_seq[%0d]: got %b want %b", k, {out_valid, out_last, out}, {1'b1, 1'(k == 3), N'(8 - k)});
      end
    end
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL post_reset_idle: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_toggle();
    logic       rdy [6];
    logic [4:0] exp [6];
    rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    exp = '{5'b10_011, 5'b10_011, 5'b10_010, 5'b10_010, 5'b11_001, 5'b11_001};
    out_ready = 1'b1;
    write_batch(1);
    step();
    n_cmp++;
    if ({out_valid, out_last, out} !== 5'b10_100) begin
      n_err++; $display("FAIL toggle_first: got %b want %b", {out_valid, out_last, out}, 5'b10_100);
    end
    for (int j = 0; j < 6; j++) begin
      out_ready = rdy[j];
      step();
      n_cmp++;
      if ({out_valid, out_last, out} !== exp[j]) begin
        n_err++; $display("FAIL toggle[%0d]: got %b want %b", j, {out_valid, out_last, out}, exp[j]);
      end
    end
    out_ready = 1'b1;
    step();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL toggle_idle: out_valid got %b want 0", out_valid);
    end
  endtask

`ifdef BATCH_FWD_OUT_EN
  task automatic test_fwd();
    out_ready = 1'b1;
    write_batch(1);
    for (int k = 0; k < 4; k++) begin
      step();
      n_cmp++;
      if ({out_valid, out, fwd_out} !== {1'b1, N'(4 - k), N'(k + 1)}) begin
        n_err++; $display("FAIL fwd[%0d]: got %b want %b", k, {out_valid, out, fwd_out}, {1'b1, N'(4 - k), N'(k + 1)});
      end
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_continuous();
    test_backpressure();
    test_same_edge_free();
    test_mid_reset();
    test_toggle();
`ifdef BATCH_FWD_OUT_EN
    test_fwd();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/batch_rev_buffer.md
BATCH_REV_BUFFER -- requirements
Module: batch_rev_buffer

Interface
REQ-001 SHALL have parameter N, default 3, control-signal sample width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, batch length in samples; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port in  input  N  incoming control-signal sample.
REQ-006 SHALL have port in_valid  input  1  in carries a sample this cycle.
REQ-007 SHALL have port out  output  N  sample in time-reversed batch order.
REQ-008 SHALL have port out_valid  output  1  out is valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts out this cycle.
REQ-010 SHALL have port out_last  output  1  out is the oldest (final reversed) sample of its batch.
REQ-011 SHALL have port overflow  output  1  sticky flag: at least one input sample was dropped.

Function
REQ-012 SHALL hold two banks (0, 1) of DEPTH N-bit entries, a per-bank full flag, a write bank wb, a write pointer wp, a read bank rb and a read pointer rp.
REQ-013 When in_valid=1 and bank wb is not full, SHALL write in to bank wb at index wp and increment wp.
REQ-014 On the write with wp=DEPTH-1, SHALL set full[wb], toggle wb and reset wp to 0 at the same edge.
REQ-015 When in_valid=1 and full[wb]=1, SHALL drop the sample, leave wp unchanged and set overflow.
REQ-016 Full flags SHALL be sampled before the edge: a write to a bank that is freed at the same edge SHALL be dropped.
REQ-017 Read FSM SHALL have two states: IDLE (out_valid=0) and READ (out_valid=1).
REQ-018 IDLE->READ at the first edge where any full flag is set: load the oldest full bank into rb, set rp=DEPTH-1 and register out=mem[rb][DEPTH-1].
REQ-019 Latency: last sample of a batch written at edge E SHALL give out_valid=1 after edge E+1, provided the reader is IDLE.
REQ-020 A transfer SHALL occur when out_valid=1 and out_ready=1; with out_valid=1 and out_ready=0, out, out_last and out_valid SHALL hold stable.
REQ-021 On a transfer with rp>0, SHALL decrement rp and register out=mem[rb][rp-1].
REQ-022 out_last SHALL equal 1 exactly when out_valid=1 and rp=0.
REQ-023 On a transfer with rp=0, SHALL clear full[rb]; if the other bank is full, switch rb, set rp=DEPTH-1 and stay in READ with no bubble; otherwise go to IDLE with out_valid=0.
REQ-024 Sustained throughput with out_ready=1 SHALL be one sample per cycle with no drops.

Reset
REQ-025 rst=1 SHALL immediately force: out=0, out_valid=0, out_last=0, overflow=0, both full flags=0, wb=0, wp=0, rb=0, rp=0, FSM=IDLE.
REQ-026 Reset mid-batch or mid-read SHALL discard all buffered samples; bank contents need not be cleared.
REQ-027 overflow SHALL clear only on rst.

Configuration
REQ-028 With macro BATCH_FWD_OUT_EN defined, SHALL add port fwd_out  output  N, registered alongside out, carrying mem[rb][DEPTH-1-rp] (forward order), sharing out_valid, out_ready and out_last; reset value 0.
REQ-029 Without BATCH_FWD_OUT_EN, fwd_out SHALL be absent and the rest of the behaviour SHALL be identical.

Verification (N=3, DEPTH=4)
REQ-030 in=1,2,3,4 valid on consecutive cycles, out_ready=1 -> out=4,3,2,1 on 4 consecutive cycles starting the cycle after the 4th write edge; out_last only with 1.
REQ-031 Continuous in=0..7, out_ready=1 -> out=3,2,1,0,7,6,5,4 with no gaps; overflow stays 0.
REQ-032 out_ready=0 while 12 samples are written -> 8 samples buffered, samples 9-12 dropped, overflow=1; after out_ready=1 -> out=3,2,1,0,7,6,5,4, then out_valid=0.
REQ-033 After 2 of 4 samples, assert rst -> all outputs 0; then 4 new samples 5,6,7,0 -> out=0,7,6,5.
REQ-034 out_ready toggled 1,0,1,0 during a read -> each value holds while out_ready=0; sequence still 4,3,2,1.
REQ-035 With BATCH_FWD_OUT_EN, in=1,2,3,4 -> (out,fwd_out)=(4,1),(3,2),(2,3),(1,4).
